// File: rtl/cbus_qos_arbiter_pkg.sv
// Shared types for the CBus QoS arbiter: bus request/response structs,
// arbiter state encoding and an index-width helper.
package cbus_qos_arbiter_pkg;

    typedef struct packed {
        logic        valid;
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [3:0]  len;     // burst length in beats
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] rdata;
        logic        err;
    } cbus_resp_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // Width of a port index; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cbus_qos_arbiter_rr_pick.sv
// Combinational wrap-around first-one finder: returns the first set bit of
// req at or after start, wrapping past the top index back to 0.
module cbus_qos_arbiter_rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] start,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    int off;
    int best_off;

    // Pick the requester with the smallest wrapped distance from start.
    always_comb begin
        found    = 1'b0;
        idx      = '0;
        off      = 0;
        best_off = N;
        for (int j = 0; j < N; j++) begin
            if (j >= int'(start)) begin
                off = j - int'(start);
            end else begin
                off = j + N - int'(start);
            end
            if (req[j] && (off < best_off)) begin
                best_off = off;
                found    = 1'b1;
                idx      = IDX_W'(j);
            end else begin
                best_off = best_off;
            end
        end
    end

endmodule

// File: rtl/cbus_qos_arbiter.sv
// N-port CBus arbiter: round-robin or fixed-priority selection with
// starvation aging; the grant is held for a whole burst until the last beat.
module cbus_qos_arbiter
    import cbus_qos_arbiter_pkg::*;
#(
    parameter  int NUM_INPUTS = 2,
    parameter  int MAX_WAIT   = 64,
    parameter  int WAIT_W     = 8,
    localparam int IDX_W      = idx_width(NUM_INPUTS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             prio_mode,
    input  cbus_req_t        ireqs  [NUM_INPUTS],
    output cbus_resp_t       iresps [NUM_INPUTS],
    output cbus_req_t        oreq,
    input  cbus_resp_t       oresp,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx
);

    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_INPUTS - 1);

    arb_state_t             state;
    arb_state_t             next_state;
    logic [IDX_W-1:0]       sel;
    logic [IDX_W-1:0]       last_sel;
    logic [IDX_W-1:0]       rr_start;
    logic [IDX_W-1:0]       winner;
    logic [IDX_W-1:0]       aged_idx;
    logic [IDX_W-1:0]       rr_idx;
    logic [IDX_W-1:0]       fix_idx;
    logic                   aged_found;
    logic                   rr_found;
    logic                   fix_found;
    logic                   any_valid;
    logic                   done;
    logic [NUM_INPUTS-1:0]  valid_vec;
    logic [NUM_INPUTS-1:0]  aged_vec;
    logic [WAIT_W-1:0]      wait_cnt [NUM_INPUTS];

    // Collect request valids and the set of ports that have waited too long.
    always_comb begin
        valid_vec = '0;
        aged_vec  = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            valid_vec[i] = ireqs[i].valid;
            aged_vec[i]  = ireqs[i].valid && (wait_cnt[i] == WAIT_MAX);
        end
    end

    // Round-robin scan starts just after the previous owner, wrapping.
    always_comb begin
        if (last_sel == LAST_IDX) begin
            rr_start = '0;
        end else begin
            rr_start = last_sel + 1'b1;
        end
    end

    cbus_qos_arbiter_rr_pick #(.N(NUM_INPUTS), .IDX_W(IDX_W)) u_aged_pick (
        .req   (aged_vec),
        .start ('0),
        .found (aged_found),
        .idx   (aged_idx)
    );

    cbus_qos_arbiter_rr_pick #(.N(NUM_INPUTS), .IDX_W(IDX_W)) u_rr_pick (
        .req   (valid_vec),
        .start (rr_start),
        .found (rr_found),
        .idx   (rr_idx)
    );

    cbus_qos_arbiter_rr_pick #(.N(NUM_INPUTS), .IDX_W(IDX_W)) u_fix_pick (
        .req   (valid_vec),
        .start ('0),
        .found (fix_found),
        .idx   (fix_idx)
    );

    assign any_valid = fix_found;
    assign done      = (state == BUSY) && oresp.ready && oresp.last;

    // Winner: aged ports first, then the policy chosen by prio_mode.
    always_comb begin
        if (aged_found) begin
            winner = aged_idx;
        end else if (!prio_mode && rr_found) begin
            winner = rr_idx;
        end else if (fix_found) begin
            winner = fix_idx;
        end else begin
            winner = '0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next state: grant on any request, release on the final beat.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (any_valid) begin
                    next_state = BUSY;
                end else begin
                    next_state = IDLE;
                end
            end
            BUSY: begin
                if (done) begin
                    next_state = IDLE;
                end else begin
                    next_state = BUSY;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Owner capture in IDLE and previous-owner update at burst end.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel      <= '0;
            last_sel <= LAST_IDX;
        end else begin
            if ((state == IDLE) && any_valid) begin
                sel <= winner;
            end
            if (done) begin
                last_sel <= sel;
            end
        end
    end

    // Per-port saturating wait counters; cleared when the port is selected.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                wait_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                if ((state == IDLE) && any_valid && (winner == IDX_W'(i))) begin
                    wait_cnt[i] <= '0;
                end else if (valid_vec[i] &&
                             !((state == BUSY) && (sel == IDX_W'(i))) &&
                             (wait_cnt[i] < WAIT_MAX)) begin
                    wait_cnt[i] <= wait_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Data path: connect the owner to the memory side, zero everything else.
    always_comb begin
        oreq = '0;
        for (int j = 0; j < NUM_INPUTS; j++) begin
            iresps[j] = '0;
            if ((state == BUSY) && (sel == IDX_W'(j))) begin
                oreq      = ireqs[j];
                iresps[j] = oresp;
            end else begin
                iresps[j] = '0;
            end
        end
    end

    assign grant_valid = (state == BUSY);
    assign grant_idx   = sel;

endmodule

// File: tb/tb_cbus_qos_arbiter.sv
// Self-checking bench for cbus_qos_arbiter: directed scenarios plus a
// randomized run compared against a transaction-level reference model.
module tb_cbus_qos_arbiter;
    import cbus_qos_arbiter_pkg::*;

    localparam int N  = 3;
    localparam int MW = 4;
    localparam int WW = 8;
    localparam int IW = idx_width(N);

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            prio_mode = 1'b0;
    cbus_req_t       ireqs  [N];
    cbus_resp_t      iresps [N];
    cbus_req_t       oreq;
    cbus_resp_t      oresp;
    logic            grant_valid;
    logic [IW-1:0]   grant_idx;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit m_busy;
    int m_sel, m_last, m_beats, m_done;
    int m_wait [N];

    always #5 clk = ~clk;

    cbus_qos_arbiter #(.NUM_INPUTS(N), .MAX_WAIT(MW), .WAIT_W(WW)) dut (
        .clk         (clk),
        .reset       (reset),
        .prio_mode   (prio_mode),
        .ireqs       (ireqs),
        .iresps      (iresps),
        .oreq        (oreq),
        .oresp       (oresp),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    task automatic model_reset();
        m_busy  = 1'b0;
        m_sel   = 0;
        m_last  = N - 1;
        m_beats = 0;
        m_done  = -1;
        for (int i = 0; i < N; i++) m_wait[i] = 0;
    endtask

    function automatic int model_pick();
        for (int i = 0; i < N; i++)
            if (ireqs[i].valid && m_wait[i] == MW) return i;
        if (!prio_mode) begin
            for (int k = 1; k <= N; k++)
                if (ireqs[(m_last + k) % N].valid) return (m_last + k) % N;
        end
        for (int i = 0; i < N; i++)
            if (ireqs[i].valid) return i;
        return -1;
    endfunction

    task automatic model_update();
        int win;
        win    = m_busy ? -1 : model_pick();
        m_done = -1;
        for (int i = 0; i < N; i++) begin
            if (i == win) m_wait[i] = 0;
            else if (ireqs[i].valid && !(m_busy && m_sel == i) && m_wait[i] < MW)
                m_wait[i] = m_wait[i] + 1;
        end
        if (win >= 0) begin
            m_busy  = 1'b1;
            m_sel   = win;
            m_beats = 0;
        end else if (m_busy && oresp.ready && oresp.last) begin
            m_last = m_sel;
            m_done = m_sel;
            m_busy = 1'b0;
        end else if (m_busy && oresp.ready) begin
            m_beats = m_beats + 1;
        end
    endtask

    function automatic cbus_req_t mk_req(input int l);
        cbus_req_t r;
        r.valid = 1'b1;
        r.write = 1'($urandom_range(0, 1));
        r.addr  = $urandom;
        r.wdata = $urandom;
        r.wstrb = 4'hf;
        r.len   = 4'(l);
        return r;
    endfunction

    // Memory-side responder: last is raised on the final beat of the owner's burst.
    task automatic set_resp(input bit rdy);
        oresp.ready = rdy;
        oresp.rdata = $urandom;
        oresp.err   = 1'($urandom_range(0, 1));
        if (m_busy) oresp.last = rdy && (m_beats + 1 >= int'(ireqs[m_sel].len));
        else        oresp.last = 1'($urandom_range(0, 1));
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        prio_mode = 1'b0;
        for (int i = 0; i < N; i++) ireqs[i] = '0;
        oresp = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_checks++; if (grant_valid !== 1'b0) begin n_fail++; $display("FAIL reset_gv: got %b want 0", grant_valid); end
        n_checks++; if (grant_idx !== '0) begin n_fail++; $display("FAIL reset_gidx: got %0d want 0", grant_idx); end
        n_checks++; if (oreq !== '0) begin n_fail++; $display("FAIL reset_oreq: got %h want 0", oreq); end
        for (int j = 0; j < N; j++) begin
            n_checks++; if (iresps[j] !== '0) begin n_fail++; $display("FAIL reset_iresp%0d: got %h want 0", j, iresps[j]); end
        end
    endtask

    task automatic test_single();
        do_reset();
        repeat (4) begin set_resp(1'b0); tick(); end
        ireqs[1] = mk_req(1);
        ireqs[1].addr  = 32'h8000_0000;
        ireqs[1].write = 1'b0;
        set_resp(1'b0); #1;
        n_checks++; if (oreq.valid !== 1'b0) begin n_fail++; $display("FAIL single_latency: got %b want 0", oreq.valid); end
        tick();
        set_resp(1'b0); #1;
        n_checks++; if (grant_valid !== 1'b1 || grant_idx !== IW'(1)) begin n_fail++; $display("FAIL single_grant: got %b/%0d want 1/1", grant_valid, grant_idx); end
        n_checks++; if (oreq !== ireqs[1]) begin n_fail++; $display("FAIL single_oreq: got %h want %h", oreq, ireqs[1]); end
        n_checks++; if (iresps[1].ready !== 1'b0) begin n_fail++; $display("FAIL single_notready: got %b want 0", iresps[1].ready); end
        tick();
        set_resp(1'b1); #1;
        n_checks++; if (iresps[1] !== oresp || iresps[1].ready !== 1'b1) begin n_fail++; $display("FAIL single_resp: got %h want %h", iresps[1], oresp); end
        n_checks++; if (iresps[0] !== '0) begin n_fail++; $display("FAIL single_other: got %h want 0", iresps[0]); end
        tick();
        ireqs[1] = '0;
        set_resp(1'b0); #1;
        n_checks++; if (grant_valid !== 1'b0 || oreq !== '0) begin n_fail++; $display("FAIL single_release: got %b/%h want 0/0", grant_valid, oreq); end
        tick();
    endtask

    task automatic test_round_robin();
        do_reset();
        ireqs[0] = mk_req(1);
        ireqs[1] = mk_req(1);
        for (int c = 0; c < 12; c++) begin
            set_resp(1'b1); #1;
            n_checks++; if (grant_valid !== 1'(c % 2)) begin n_fail++; $display("FAIL rr_gv c%0d: got %b want %0d", c, grant_valid, c % 2); end
            if (c % 2 == 1) begin
                n_checks++; if (grant_idx !== IW'((c / 2) % 2)) begin n_fail++; $display("FAIL rr_idx c%0d: got %0d want %0d", c, grant_idx, (c / 2) % 2); end
            end
            tick();
        end
    endtask

    task automatic test_burst_lock();
        do_reset();
        ireqs[0] = mk_req(4);
        ireqs[1] = mk_req(1);
        for (int c = 0; c < 7; c++) begin
            set_resp(1'b1); #1;
            if (c >= 1 && c <= 4) begin
                n_checks++; if (grant_valid !== 1'b1 || grant_idx !== IW'(0)) begin n_fail++; $display("FAIL burst_owner c%0d: got %b/%0d want 1/0", c, grant_valid, grant_idx); end
                n_checks++; if (iresps[1] !== '0) begin n_fail++; $display("FAIL burst_blocked c%0d: got %h want 0", c, iresps[1]); end
                n_checks++; if (iresps[0] !== oresp) begin n_fail++; $display("FAIL burst_resp c%0d: got %h want %h", c, iresps[0], oresp); end
            end else if (c == 6) begin
                n_checks++; if (grant_valid !== 1'b1 || grant_idx !== IW'(1)) begin n_fail++; $display("FAIL burst_next: got %b/%0d want 1/1", grant_valid, grant_idx); end
            end else begin
                n_checks++; if (grant_valid !== 1'b0) begin n_fail++; $display("FAIL burst_idle c%0d: got %b want 0", c, grant_valid); end
            end
            tick();
            if (c == 4) ireqs[0] = '0;
        end
    endtask

    task automatic test_aging();
        int exp_idx [4] = '{0, 0, 1, 0};
        do_reset();
        prio_mode = 1'b1;
        ireqs[0] = mk_req(1);
        ireqs[1] = mk_req(1);
        for (int c = 0; c < 8; c++) begin
            set_resp(1'b1); #1;
            if (c % 2 == 1) begin
                n_checks++; if (grant_valid !== 1'b1 || grant_idx !== IW'(exp_idx[c / 2])) begin n_fail++; $display("FAIL aging_grant c%0d: got %b/%0d want 1/%0d", c, grant_valid, grant_idx, exp_idx[c / 2]); end
            end else begin
                n_checks++; if (grant_valid !== 1'b0) begin n_fail++; $display("FAIL aging_idle c%0d: got %b want 0", c, grant_valid); end
            end
            if (c == 5) begin
                n_checks++; if (dut.wait_cnt[1] !== 8'd0) begin n_fail++; $display("FAIL aging_clear: got %0d want 0", dut.wait_cnt[1]); end
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        ireqs[0] = mk_req(4);
        ireqs[1] = mk_req(1);
        set_resp(1'b0); tick();
        set_resp(1'b1); tick();
        set_resp(1'b1); #1;
        n_checks++; if (grant_valid !== 1'b1 || oreq.valid !== 1'b1) begin n_fail++; $display("FAIL areset_pre: got %b/%b want 1/1", grant_valid, oreq.valid); end
        #1 reset = 1'b1;
        #1;
        n_checks++; if (grant_valid !== 1'b0 || oreq.valid !== 1'b0) begin n_fail++; $display("FAIL areset_release: got %b/%b want 0/0", grant_valid, oreq.valid); end
        n_checks++; if (iresps[0] !== '0) begin n_fail++; $display("FAIL areset_iresp: got %h want 0", iresps[0]); end
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        set_resp(1'b0); #1;
        n_checks++; if (grant_valid !== 1'b0) begin n_fail++; $display("FAIL areset_idle: got %b want 0", grant_valid); end
        tick();
        set_resp(1'b0); #1;
        n_checks++; if (grant_valid !== 1'b1 || grant_idx !== IW'(0)) begin n_fail++; $display("FAIL areset_first: got %b/%0d want 1/0", grant_valid, grant_idx); end
        tick();
    endtask

    task automatic test_mode_toggle();
        do_reset();
        ireqs[0] = mk_req(2);
        set_resp(1'b0); tick();
        prio_mode = 1'b1;
        ireqs[1] = mk_req(1);
        set_resp(1'b1); #1;
        n_checks++; if (grant_valid !== 1'b1 || grant_idx !== IW'(0) || oreq !== ireqs[0]) begin n_fail++; $display("FAIL toggle_hold1: got %b/%0d want 1/0", grant_valid, grant_idx); end
        tick();
        set_resp(1'b1); #1;
        n_checks++; if (grant_valid !== 1'b1 || grant_idx !== IW'(0)) begin n_fail++; $display("FAIL toggle_hold2: got %b/%0d want 1/0", grant_valid, grant_idx); end
        tick();
        set_resp(1'b0); #1;
        n_checks++; if (grant_valid !== 1'b0) begin n_fail++; $display("FAIL toggle_idle: got %b want 0", grant_valid); end
        tick();
        set_resp(1'b0); #1;
        n_checks++; if (grant_valid !== 1'b1 || grant_idx !== IW'(0)) begin n_fail++; $display("FAIL toggle_fixed: got %b/%0d want 1/0", grant_valid, grant_idx); end
        tick();
    endtask

    task automatic test_random();
        cbus_req_t  eq;
        cbus_resp_t er;
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < N; i++)
                if (!ireqs[i].valid && $urandom_range(0, 3) == 0)
                    ireqs[i] = mk_req($urandom_range(1, 4));
            if ($urandom_range(0, 15) == 0) prio_mode = ~prio_mode;
            set_resp($urandom_range(0, 2) != 0);
            #1;
            eq = m_busy ? ireqs[m_sel] : '0;
            n_checks++; if (grant_valid !== m_busy) begin n_fail++; $display("FAIL rnd_gv c%0d: got %b want %b", c, grant_valid, m_busy); end
            n_checks++; if (grant_idx !== IW'(m_sel)) begin n_fail++; $display("FAIL rnd_idx c%0d: got %0d want %0d", c, grant_idx, m_sel); end
            n_checks++; if (oreq !== eq) begin n_fail++; $display("FAIL rnd_oreq c%0d: got %h want %h", c, oreq, eq); end
            for (int j = 0; j < N; j++) begin
                er = (m_busy && m_sel == j) ? oresp : '0;
                n_checks++; if (iresps[j] !== er) begin n_fail++; $display("FAIL rnd_iresp%0d c%0d: got %h want %h", j, c, iresps[j], er); end
            end
            tick();
            if (m_done >= 0) ireqs[m_done] = '0;
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) ireqs[i] = '0;
        oresp = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_burst_lock();
        test_aging();
        test_async_reset();
        test_mode_toggle();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
